pipe_hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage pipelined datapath.

---
 rtl/pipe_hazard_unit.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_unit
//  Purpose  : Hazard / forwarding controller for a 5-stage pipeline. Keeps a
//             three-entry scoreboard (EXE, MEM, WB) of in-flight destination
//             registers. From it the unit produces the per-source operand
//             forwarding selects, the load-use interlock, a bubble for
//             branch flushes, and honours an external pipeline freeze.
//  Config   : HAZ_PERF_CNT_EN -- when defined, builds a saturating counter
//             of load-use stall cycles. When undefined, stall_cnt_o is 0.
//  Ports    : clk            pipeline clock, rising edge
//             rst_n          asynchronous active-low reset
//             ext_stall_i    freeze the whole pipeline
//             flush_i        kill the instruction currently in ID
//             id_valid_i     ID holds a real instruction
//             id_src_i       source regs, src k = [k*AW +: AW]
//             id_src_used_i  bit k: src k is actually read
//             id_dest_i      destination reg of the ID instruction
//             id_wreg_i      ID instruction writes the register file
//             id_m2reg_i     ID instruction is a load
//             fwd_sel_o      per-source select, sel k = [2k +: 2]
//                            01 = EXE ALU, 11 = MEM load, 10 = MEM ALU,
//                            00 = register file
//             stall_o        hold the PC and the IF/ID register
//             bubble_o       zero the ID/EXE control (insert a NOP)
//             stall_cnt_o    load-use stall cycles (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ext_stall_i,
    input  logic                   flush_i,
    input  logic                   id_valid_i,
    input  logic [NUM_SRC*AW-1:0]  id_src_i,
    input  logic [NUM_SRC-1:0]     id_src_used_i,
    input  logic [AW-1:0]          id_dest_i,
    input  logic                   id_wreg_i,
    input  logic                   id_m2reg_i,
    output logic [2*NUM_SRC-1:0]   fwd_sel_o,
    output logic                   stall_o,
    output logic                   bubble_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    // ------------------------------------------------------------------
    // Scoreboard entries
    // ------------------------------------------------------------------
    logic          exe_valid_q, exe_wreg_q, exe_m2reg_q;
    logic [AW-1:0] exe_dest_q;
    logic          mem_valid_q, mem_wreg_q, mem_m2reg_q;
    logic [AW-1:0] mem_dest_q;
    logic          wb_valid_q, wb_wreg_q, wb_m2reg_q;
    logic [AW-1:0] wb_dest_q;

    logic          exe_valid_d, exe_wreg_d, exe_m2reg_d;
    logic [AW-1:0] exe_dest_d;

    logic [NUM_SRC-1:0] w_lu_vec;
    logic               w_lu;

    // ------------------------------------------------------------------
    // Per-source forwarding and load-use detection
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [AW-1:0] w_src;
        logic          w_used;
        logic          w_exe_hit;
        logic          w_mem_hit;

        assign w_src     = id_src_i[k*AW +: AW];
        assign w_used    = id_valid_i & id_src_used_i[k];
        // Register 0 is hard-wired zero, so it never matches.
        assign w_exe_hit = w_used & exe_valid_q & exe_wreg_q &
                           (exe_dest_q == w_src) & (w_src != '0);
        assign w_mem_hit = w_used & mem_valid_q & mem_wreg_q &
                           (mem_dest_q == w_src) & (w_src != '0);

        // The EXE entry is younger, so it shadows any MEM match. An EXE load
        // has no data yet: the select stays 00 while the interlock holds ID.
        always_comb begin
            fwd_sel_o[2*k +: 2] = 2'b00;
            if (w_exe_hit) begin
                fwd_sel_o[2*k +: 2] = exe_m2reg_q ? 2'b00 : 2'b01;
            end else if (w_mem_hit) begin
                fwd_sel_o[2*k +: 2] = mem_m2reg_q ? 2'b11 : 2'b10;
            end
        end

        assign w_lu_vec[k] = w_exe_hit & exe_m2reg_q;
    end

    // A flushed instruction is dropped, so it never needs to wait.
    assign w_lu     = id_valid_i & ~flush_i & (|w_lu_vec);
    assign stall_o  = w_lu;
    assign bubble_o = w_lu | flush_i | ~id_valid_i;

    // ------------------------------------------------------------------
    // Scoreboard advance
    // ------------------------------------------------------------------
    always_comb begin
        exe_valid_d = 1'b0;
        exe_dest_d  = '0;
        exe_wreg_d  = 1'b0;
        exe_m2reg_d = 1'b0;
        if (!bubble_o) begin
            exe_valid_d = 1'b1;
            exe_dest_d  = id_dest_i;
            exe_wreg_d  = id_wreg_i;
            exe_m2reg_d = id_m2reg_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q <= 1'b0;
            exe_dest_q  <= '0;
            exe_wreg_q  <= 1'b0;
            exe_m2reg_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= '0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= '0;
            wb_wreg_q   <= 1'b0;
            wb_m2reg_q  <= 1'b0;
        end else if (!ext_stall_i) begin
            exe_valid_q <= exe_valid_d;
            exe_dest_q  <= exe_dest_d;
            exe_wreg_q  <= exe_wreg_d;
            exe_m2reg_q <= exe_m2reg_d;
            mem_valid_q <= exe_valid_q;
            mem_dest_q  <= exe_dest_q;
            mem_wreg_q  <= exe_wreg_q;
            mem_m2reg_q <= exe_m2reg_q;
            wb_valid_q  <= mem_valid_q;
            wb_dest_q   <= mem_dest_q;
            wb_wreg_q   <= mem_wreg_q;
            wb_m2reg_q  <= mem_m2reg_q;
        end
    end

    // The WB entry is tracked for completeness only. The register file
    // writes on the falling edge, so ID reads the value without forwarding.
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_valid_q, wb_dest_q, wb_wreg_q, wb_m2reg_q};

    // ------------------------------------------------------------------
    // Load-use stall counter
    // ------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (w_lu && !ext_stall_i && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_unit
//  Purpose  : Directed self-checking bench for pipe_hazard_unit. A second
//             instance with a 2-bit counter shares the stimulus and is used
//             to observe counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_unit;

`ifdef HAZ_PERF_CNT_EN
    localparam bit c_CNT_ON = 1'b1;
`else
    localparam bit c_CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ext_stall;
    logic        flush;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dest;
    logic        id_wreg;
    logic        id_m2reg;
    logic [3:0]  fwd_sel, fwd_sel2;
    logic        stall, stall2;
    logic        bubble, bubble2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    pipe_hazard_unit #(.AW(5), .NUM_SRC(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ext_stall_i(ext_stall), .flush_i(flush),
        .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(id_src_used),
        .id_dest_i(id_dest), .id_wreg_i(id_wreg), .id_m2reg_i(id_m2reg),
        .fwd_sel_o(fwd_sel), .stall_o(stall), .bubble_o(bubble),
        .stall_cnt_o(stall_cnt)
    );

    pipe_hazard_unit #(.AW(5), .NUM_SRC(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ext_stall_i(ext_stall), .flush_i(flush),
        .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(id_src_used),
        .id_dest_i(id_dest), .id_wreg_i(id_wreg), .id_m2reg_i(id_m2reg),
        .fwd_sel_o(fwd_sel2), .stall_o(stall2), .bubble_o(bubble2),
        .stall_cnt_o(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive the ID stage, then let the combinational outputs settle.
    task automatic id_set(input logic v, input logic [4:0] s0,
                          input logic [4:0] s1, input logic [1:0] used,
                          input logic [4:0] d, input logic w, input logic m);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dest     = d;
        id_wreg     = w;
        id_m2reg    = m;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        id_set(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain;
        for (int i = 0; i < 3; i++) begin
            nop();
            tick();
        end
    endtask

    task automatic lu_count;
        if (c_CNT_ON) exp_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; ext_stall = 1'b0; flush = 1'b0;
        nop();
        #12;
        // Reset state
        check_val("rst_fwd", fwd_sel, 0);
        check_val("rst_stall", stall, 0);
        check_val("rst_bubble_idle", bubble, 1);
        check_val("rst_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        tick();

        // 1. ALU chain, back to back: add $3,$1,$2 ; sub $4,$3,$5
        id_set(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0);
        check_val("alu_first_fwd", fwd_sel, 0);
        check_val("alu_first_bubble", bubble, 0);
        tick();
        id_set(1, 5'd3, 5'd5, 2'b11, 5'd4, 1, 0);
        check_val("alu_b2b_fwd", fwd_sel, 4'b0001);
        check_val("alu_b2b_stall", stall, 0);
        tick();
        drain();
        // ALU chain with one NOP between
        id_set(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0);
        tick();
        nop();
        tick();
        id_set(1, 5'd3, 5'd5, 2'b11, 5'd4, 1, 0);
        check_val("alu_nop_fwd", fwd_sel, 4'b0010);
        // Unused source must not forward
        id_set(1, 5'd3, 5'd5, 2'b10, 5'd4, 1, 0);
        check_val("alu_unused_fwd", fwd_sel, 0);
        tick();
        drain();

        // Same dest in EXE and MEM: add $3,$6,$7 twice, then sub $4,$3,$3
        id_set(1, 5'd6, 5'd7, 2'b11, 5'd3, 1, 0);
        tick();
        id_set(1, 5'd6, 5'd7, 2'b11, 5'd3, 1, 0);
        tick();
        id_set(1, 5'd3, 5'd3, 2'b11, 5'd4, 1, 0);
        check_val("younger_fwd", fwd_sel, 4'b0101);
        tick();
        drain();

        // 2. Load-use: lw $8,0($9) ; add $10,$8,$8
        id_set(1, 5'd9, 5'd0, 2'b01, 5'd8, 1, 1);
        tick();
        id_set(1, 5'd8, 5'd8, 2'b11, 5'd10, 1, 0);
        check_val("lu_stall", stall, 1);
        check_val("lu_bubble", bubble, 1);
        check_val("lu_fwd", fwd_sel, 0);
        tick();
        lu_count();
        check_val("lu_after_stall", stall, 0);
        check_val("lu_after_bubble", bubble, 0);
        check_val("lu_after_fwd", fwd_sel, 4'b1111);
        check_val("lu_cnt", stall_cnt, exp_cnt);
        tick();
        drain();

        // 3. $0 destination: addi $0,$1,5 ; add $2,$0,$0
        id_set(1, 5'd1, 5'd0, 2'b01, 5'd0, 1, 0);
        tick();
        id_set(1, 5'd0, 5'd0, 2'b11, 5'd2, 1, 0);
        check_val("r0_fwd", fwd_sel, 0);
        check_val("r0_stall", stall, 0);
        tick();
        drain();

        // 4. Flush during load-use
        id_set(1, 5'd9, 5'd0, 2'b01, 5'd8, 1, 1);
        tick();
        flush = 1'b1;
        id_set(1, 5'd8, 5'd0, 2'b01, 5'd10, 1, 0);
        check_val("flush_stall", stall, 0);
        check_val("flush_bubble", bubble, 1);
        tick();
        flush = 1'b0;
        id_set(1, 5'd10, 5'd10, 2'b11, 5'd11, 1, 0);
        check_val("flush_next_fwd", fwd_sel, 0);
        check_val("flush_next_stall", stall, 0);
        check_val("flush_cnt", stall_cnt, exp_cnt);
        tick();
        drain();

        // 5. ext_stall with a load in EXE and its consumer in ID
        id_set(1, 5'd9, 5'd0, 2'b01, 5'd8, 1, 1);
        tick();
        ext_stall = 1'b1;
        id_set(1, 5'd8, 5'd8, 2'b11, 5'd10, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check_val("frz_stall", stall, 1);
            check_val("frz_cnt", stall_cnt, exp_cnt);
            tick();
        end
        ext_stall = 1'b0;
        #1;
        check_val("frz_rel_stall", stall, 1);
        tick();
        lu_count();
        check_val("frz_done_stall", stall, 0);
        check_val("frz_done_fwd", fwd_sel, 4'b1111);
        check_val("frz_done_cnt", stall_cnt, exp_cnt);
        tick();
        drain();

        // 6. Reset mid-run with valid EXE/MEM entries
        id_set(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0);
        tick();
        id_set(1, 5'd1, 5'd2, 2'b11, 5'd4, 1, 0);
        tick();
        id_set(1, 5'd4, 5'd3, 2'b11, 5'd5, 1, 0);
        check_val("pre_rst_fwd", fwd_sel, 4'b1001);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_fwd", fwd_sel, 0);
        check_val("mid_rst_stall", stall, 0);
        check_val("mid_rst_cnt", stall_cnt, 0);
        check_val("mid_rst_cnt2", stall_cnt2, 0);
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        drain();

        // Saturation: five load-use stalls
        for (int i = 0; i < 5; i++) begin
            id_set(1, 5'd9, 5'd0, 2'b01, 5'd8, 1, 1);
            tick();
            id_set(1, 5'd8, 5'd8, 2'b11, 5'd10, 1, 0);
            check_val("sat_stall", stall, 1);
            tick();
            lu_count();
            tick();
        end
        check_val("sat_cnt16", stall_cnt, exp_cnt);
        check_val("sat_cnt2", stall_cnt2, c_CNT_ON ? 3 : 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
